// File: rtl/cr_sa_counter_bank.sv
// cr_sa_counter_bank: statistics-aggregator counter bank.
// Registers a flat vector of engine stat event bits and runs N_CNT counters,
// each selecting one event bit, with per-counter enable, wrap/saturate mode,
// sticky overflow flags, edge-triggered snapshot and edge-triggered clear.
//
// Build option: define CR_SA_CLEAR_ON_SNAP_EN to make every snapshot also
// clear counts and overflow flags (read-and-clear).
//
// Ports:
//   clk                 clock
//   rst_n               synchronous active-low reset
//   stat_events         raw event bits, bit g*GRP_W+b = group g bit b
//   regs_sa_snap        snapshot request level (rising edge acts)
//   regs_sa_clear_live  clear request level (rising edge acts)
//   regs_sa_event_sel   per-counter flat event index, SEL_W bits each
//   regs_sa_cnt_en      per-counter count enable
//   regs_sa_sat_mode    per-counter 1 = saturate, 0 = wrap
//   sa_count            live counts, CNT_W bits each
//   sa_snapshot         snapshot values, CNT_W bits each
//   sa_ovf              sticky overflow/saturation flags
//   sa_snap_done        one-cycle pulse when sa_snapshot updates
module cr_sa_counter_bank #(
    parameter int unsigned N_CNT = 64,
    parameter int unsigned N_GRP = 16,
    parameter int unsigned GRP_W = 64,
    parameter int unsigned CNT_W = 50,
    parameter int unsigned SEL_W = $clog2(N_GRP * GRP_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_GRP*GRP_W-1:0]   stat_events,
    input  logic                     regs_sa_snap,
    input  logic                     regs_sa_clear_live,
    input  logic [N_CNT*SEL_W-1:0]   regs_sa_event_sel,
    input  logic [N_CNT-1:0]         regs_sa_cnt_en,
    input  logic [N_CNT-1:0]         regs_sa_sat_mode,
    output logic [N_CNT*CNT_W-1:0]   sa_count,
    output logic [N_CNT*CNT_W-1:0]   sa_snapshot,
    output logic [N_CNT-1:0]         sa_ovf,
    output logic                     sa_snap_done
);

    localparam int unsigned EV_W    = N_GRP * GRP_W;
    localparam int unsigned EV_SPAN = 32'(1) << SEL_W;

    logic [EV_W-1:0]    r_ev;
    logic               r_snap_hist;
    logic               r_clr_hist;
    logic               r_snap_p;
    logic               r_clr_p;
    logic               r_snap_done;
    logic [CNT_W-1:0]   r_cnt  [N_CNT];
    logic [CNT_W-1:0]   r_snap [N_CNT];
    logic [N_CNT-1:0]   r_ovf;

    logic [EV_SPAN-1:0] w_ev_span;
    logic [N_CNT-1:0]   w_inc;
    logic               w_clr;
    logic [CNT_W-1:0]   w_cnt_nxt [N_CNT];
    logic [N_CNT-1:0]   w_ovf_nxt;

    // Zero-pad the event vector to the full select span so out-of-range
    // selects read a constant 0 and never count.
    if (EV_SPAN > EV_W) begin : g_ev_pad
        assign w_ev_span = {{(EV_SPAN - EV_W){1'b0}}, r_ev};
    end else begin : g_ev_nopad
        assign w_ev_span = r_ev;
    end

    // Per-counter event select and output flattening.
    for (genvar gi = 0; gi < int'(N_CNT); gi++) begin : g_cnt
        logic [SEL_W-1:0] w_sel;
        assign w_sel      = regs_sa_event_sel[gi*SEL_W +: SEL_W];
        assign w_inc[gi]  = w_ev_span[w_sel] & regs_sa_cnt_en[gi];
        assign sa_count[gi*CNT_W +: CNT_W]    = r_cnt[gi];
        assign sa_snapshot[gi*CNT_W +: CNT_W] = r_snap[gi];
    end

`ifdef CR_SA_CLEAR_ON_SNAP_EN
    assign w_clr = r_clr_p | r_snap_p;
`else
    assign w_clr = r_clr_p;
`endif

    // Next count/overflow: clear beats increment; terminal count wraps or holds.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        for (int unsigned i = 0; i < N_CNT; i++) begin
            if (w_clr) begin
                w_cnt_nxt[i] = '0;
                w_ovf_nxt[i] = 1'b0;
            end else if (w_inc[i]) begin
                if (&r_cnt[i]) begin
                    w_ovf_nxt[i] = 1'b1;
                    if (!regs_sa_sat_mode[i]) begin
                        w_cnt_nxt[i] = '0;
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Event stage, edge detect, counters and snapshot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ev        <= '0;
            r_snap_hist <= 1'b0;
            r_clr_hist  <= 1'b0;
            r_snap_p    <= 1'b0;
            r_clr_p     <= 1'b0;
            r_snap_done <= 1'b0;
            r_ovf       <= '0;
            for (int unsigned i = 0; i < N_CNT; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_ev        <= stat_events;
            r_snap_hist <= regs_sa_snap;
            r_clr_hist  <= regs_sa_clear_live;
            r_snap_p    <= regs_sa_snap & ~r_snap_hist;
            r_clr_p     <= regs_sa_clear_live & ~r_clr_hist;
            r_snap_done <= r_snap_p;
            r_ovf       <= w_ovf_nxt;
            for (int unsigned i = 0; i < N_CNT; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                // Snapshot takes the count before this cycle's update.
                if (r_snap_p) begin
                    r_snap[i] <= r_cnt[i];
                end
            end
        end
    end

    assign sa_ovf       = r_ovf;
    assign sa_snap_done = r_snap_done;

endmodule

// File: doc/cr_sa_counter_bank.md
Name: cr_sa_counter_bank

Overview:
- Parametrised statistics-aggregator counter bank: next generation of the CCEIP stats aggregator core.
- Registers a flat vector of per-engine stat event bits (N_GRP groups x GRP_W bits) and runs N_CNT event-selectable counters with snapshot and clear.
- Adds over the previous generation: per-counter enable, wrap/saturate mode and sticky overflow flags.
- Sits between the engine stat_events buses and the SA register block.

Parameters:
- N_CNT, 64, number of counters.
- N_GRP, 16, number of event groups.
- GRP_W, 64, event bits per group.
- CNT_W, 50, counter width.
- SEL_W, $clog2(N_GRP*GRP_W), event select width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- stat_events  input  N_GRP*GRP_W  raw event bits; bit g*GRP_W+b is group g, bit b.
- regs_sa_snap  input  1  snapshot request level; rising edge acts.
- regs_sa_clear_live  input  1  clear request level; rising edge acts.
- regs_sa_event_sel  input  N_CNT*SEL_W  per-counter flat event index.
- regs_sa_cnt_en  input  N_CNT  per-counter count enable.
- regs_sa_sat_mode  input  N_CNT  per counter: 1 = saturate, 0 = wrap.
- sa_count  output  N_CNT*CNT_W  live counts.
- sa_snapshot  output  N_CNT*CNT_W  snapshot values.
- sa_ovf  output  N_CNT  sticky overflow/saturation flags.
- sa_snap_done  output  1  one-cycle pulse when the snapshot registers update.

Behaviour:
- Reset (rst_n low at posedge clk): all sa_count, sa_snapshot and sa_ovf = 0; sa_snap_done = 0; event pipeline register = 0; edge-detect history = 0. Reset mid-operation discards all state.
- Event stage: ev_r <= stat_events every cycle.
- Counting: counter i increments when ev_r[regs_sa_event_sel[i]] = 1 and regs_sa_cnt_en[i] = 1.
- Latency: event high in input cycle t -> sa_count visible incremented after edge t+2. One increment per cycle maximum.
- Select out of range (index >= N_GRP*GRP_W): never increments.
- Select or enable change: applies on the next cycle; count is preserved.
- Edge detect: snap_p <= regs_sa_snap & ~snap_r, and clr_p <= regs_sa_clear_live & ~clr_r, both registered. A held level produces exactly one pulse. Pulses act one cycle after the input edge.
- Snapshot (snap_p): sa_snapshot[i] <= sa_count[i] (register value before that cycle's increment) for all i. sa_snap_done = 1 in the same cycle sa_snapshot updates.
- Clear (clr_p): sa_count[i] <= 0 and sa_ovf[i] <= 0 for all i. An increment in the same cycle is dropped. sa_snapshot is not affected.
- snap_p and clr_p together: snapshot takes the pre-clear value and counts go to 0 (atomic snap-and-clear).
- Terminal count (sa_count = 2^CNT_W-1) with an increment:
  - sat_mode = 1: count holds at all-ones; sa_ovf = 1.
  - sat_mode = 0: count wraps to 0; sa_ovf = 1.
- sa_ovf stays set until clr_p or reset.
- Clear and terminal-count increment in the same cycle: clear wins; sa_ovf = 0.

Optional Feature:
- Macro: CR_SA_CLEAR_ON_SNAP_EN.
- Defined: every snap_p also behaves as clr_p. Counts and ovf go to 0 in the same cycle the snapshot is taken (read-and-clear). sa_snapshot still gets the pre-clear count.
- Not defined: snap leaves counts and ovf untouched; clearing only via regs_sa_clear_live.

Test Plan:
- Count latency: reset, sel[0]=5, en[0]=1, pulse stat_events bit 5 for 3 cycles -> sa_count[0] goes 1,2,3 at edges t+2..t+4 and ends at 3; other counters stay 0.
- Held snap level: hold regs_sa_snap high 10 cycles with sa_count[3]=7 -> exactly one sa_snap_done pulse; sa_snapshot[3]=7; counts unchanged (CR_SA_CLEAR_ON_SNAP_EN undefined).
- Simultaneous snap and clear: raise snap and clear in the same cycle while counter 2 is counting every cycle at 100 -> sa_snapshot[2]=100, sa_count[2]=0 next cycle, then resumes 1,2,...
- Saturate vs wrap: CNT_W=4, counters 0 and 1 on the same always-high event, sat_mode={1,0}, 16 cycles -> sa_count[0]=15 with ovf[0]=1; sa_count[1]=0 with ovf[1]=1; after clear both ovf=0.
- Enable and out-of-range select: en[4]=0 with its event active -> count stays 0. Set en[4]=1 -> counting starts next cycle from 0. N_GRP=3, GRP_W=64, sel=200 -> never counts.
- Reset mid-run: rst_n low for 1 cycle while counters are nonzero and snap is pending -> all outputs 0 and no sa_snap_done pulse; a snap level that stays high after reset gives one fresh pulse.
